// File: rtl/seq_divider_16by8_pkg.sv
// Shared arithmetic definitions for the multiplier/divider datapath:
// default widths, divider state encoding and the divide-by-zero quotient fill.
package seq_divider_16by8_pkg;

  localparam int unsigned DIVIDEND_W_DEF = 16;
  localparam int unsigned DIVISOR_W_DEF  = 8;
  localparam int unsigned PRODUCT_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Quotient bit replicated across the full quotient on divide-by-zero.
  localparam bit DIV0_Q_FILL = 1'b1;

endpackage

// File: rtl/seq_divider_16by8_div_step.sv
// Single restoring-division iteration: shift in one dividend bit, compare
// against the divisor, conditionally subtract and emit one quotient bit.
module seq_divider_16by8_div_step
  import seq_divider_16by8_pkg::*;
#(
  parameter int unsigned DIVISOR_W = DIVISOR_W_DEF
) (
  input  logic [DIVISOR_W-1:0] i_partial,
  input  logic                 i_msb,
  input  logic [DIVISOR_W-1:0] i_divisor,
  output logic [DIVISOR_W-1:0] o_partial,
  output logic                 o_qbit
);

  logic [DIVISOR_W:0] w_trial;

  assign w_trial = {i_partial, i_msb};
  assign o_qbit  = (w_trial >= {1'b0, i_divisor});
  // The difference is always below the divisor, so its low bits are exact.
  assign o_partial = o_qbit ? (w_trial[DIVISOR_W-1:0] - i_divisor)
                            : w_trial[DIVISOR_W-1:0];

endmodule

// File: rtl/seq_divider_16by8.sv
// Iterative radix-2 restoring divider, one quotient bit per clock. Results are
// held in dedicated output registers that update only on entry to DONE.
module seq_divider_16by8
  import seq_divider_16by8_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [DIVIDEND_W-1:0] r_shift;
  logic [DIVISOR_W-1:0]  r_divisor;
  // The partial remainder stays below the divisor, so its extra top bit is
  // always zero and only exists inside the step cell's trial value.
  logic [DIVISOR_W-1:0]  r_partial;
  logic [CNT_W-1:0]      r_count;
  logic [DIVIDEND_W-1:0] r_quotient;
  logic [DIVISOR_W-1:0]  r_remainder;
  logic                  r_div_by_zero;

  logic [DIVISOR_W-1:0]  w_partial_nx;
  logic                  w_qbit;
  logic                  w_accept;
  logic                  w_zero_div;
  logic                  w_last;

  assign w_accept   = (r_state == IDLE) && start;
  assign w_zero_div = (divisor == '0);
  assign w_last     = (r_count == CNT_W'(DIVIDEND_W - 1));

  seq_divider_16by8_div_step #(
    .DIVISOR_W(DIVISOR_W)
  ) u_div_step (
    .i_partial(r_partial),
    .i_msb    (r_shift[DIVIDEND_W-1]),
    .i_divisor(r_divisor),
    .o_partial(w_partial_nx),
    .o_qbit   (w_qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = w_zero_div ? DONE : CALC;
      CALC:    if (w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift       <= '0;
      r_divisor     <= '0;
      r_partial     <= '0;
      r_count       <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else if (w_accept) begin
      if (w_zero_div) begin
        r_quotient    <= {DIVIDEND_W{DIV0_Q_FILL}};
        r_remainder   <= dividend[DIVISOR_W-1:0];
        r_div_by_zero <= 1'b1;
      end else begin
        r_shift   <= dividend;
        r_divisor <= divisor;
        r_partial <= '0;
        r_count   <= '0;
      end
    end else if (r_state == CALC) begin
      // Dividend bits leave at the top while quotient bits enter at the bottom.
      r_shift   <= {r_shift[DIVIDEND_W-2:0], w_qbit};
      r_partial <= w_partial_nx;
      r_count   <= r_count + 1'b1;
      if (w_last) begin
        r_quotient    <= {r_shift[DIVIDEND_W-2:0], w_qbit};
        r_remainder   <= w_partial_nx;
        r_div_by_zero <= 1'b0;
      end
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule
